cpu0_ifetch: RTL and testbench
==============================

// Module: cpu0_ifetch
// PURPOSE
//  Instruction fetch front-end for the CPU0 core. Reads 32-bit big-endian instructions one byte
//  at a time over a byte-wide memory port, assembles each word and buffers it with its PC in a
//  small FIFO. Hands words to the decode/execute stage through a valid/ready handshake.
//  Execute redirects it on JMP/Jxx/CALL/RET/SWI/IRET with a one-cycle flush.
// PARAMETERS
//  RESET_PC    32'h0  fetch address loaded at reset (low 2 bits must be 0)
//  FIFO_DEPTH  2      instruction buffer entries; power of 2, >=1
// PORTS
//  clock          in   1   rising-edge clock, the only clock
//  rst_n          in   1   synchronous, active-low reset
//  mem_rd         out  1   byte read request; held until accepted
//  mem_addr       out  32  byte address of the request
//  mem_ack        in   1   read accepted; transfer occurs when mem_rd&&mem_ack
//  mem_rdata      in   8   read byte, valid in the transfer cycle
//  ir_valid       out  1   ir_data/ir_pc hold a fetched instruction
//  ir_ready       in   1   consumer accepts; pop when ir_valid&&ir_ready
//  ir_data        out  32  instruction word {m[pc],m[pc+1],m[pc+2],m[pc+3]}
//  ir_pc          out  32  byte address of ir_data
//  redirect       in   1   flush and restart fetch (one-cycle pulse or level)
//  redirect_pc    in   32  new fetch address; bits [1:0] ignored (forced 0)
//  halt           in   1   stop issuing new words (level)
//  idle           out  1   FSM in HALTED with no word in assembly
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): mem_rd=0, mem_addr=0, ir_valid=0, ir_data=0, ir_pc=0, idle=0;
//   FIFO empty, byte_cnt=0, fetch_pc=RESET_PC, FSM=FETCH.
//  FSM states: FETCH, FULL_WAIT, HALTED.
//   FETCH: when byte_cnt==0 a new word starts only if FIFO count<FIFO_DEPTH and halt=0.
//    Otherwise go to FULL_WAIT (FIFO full) or HALTED (halt=1).
//    While a word is in assembly, mem_rd=1 and mem_addr=fetch_pc+byte_cnt.
//   FULL_WAIT -> FETCH once count<FIFO_DEPTH. A pop in the same cycle counts.
//   HALTED: mem_rd=0, idle=1. Returns to FETCH when halt=0.
//   halt never aborts a partially assembled word. The word completes first.
//  Byte transfer: shift {asm[23:0],mem_rdata} and increment byte_cnt.
//   On the 4th byte the word is pushed with pc=fetch_pc, then fetch_pc+=4 and byte_cnt=0.
//  Space is reserved at word start, so a push never overflows. Count cannot rise during assembly.
//  Push-to-visible latency: a word pushed at edge N is presented (ir_valid=1) after edge N.
//   FIFO head is registered.
//  Simultaneous push and pop in one cycle are both honoured; count is unchanged.
//  Timing: with mem_ack tied 1, the first mem_rd is in cycle 1 after reset release.
//   Bytes are fetched in cycles 1-4 and ir_valid=1 in cycle 5. Sustained rate is 1 word / 4 cycles.
//  Redirect has top priority in its cycle:
//   - FIFO cleared; ir_valid=0 next cycle.
//   - byte_cnt=0 and any byte transferred that cycle is discarded.
//   - fetch_pc={redirect_pc[31:2],2'b00}; FSM goes to FETCH (to HALTED if halt=1).
//   - A same-cycle pop is ignored, because the FIFO is cleared anyway.
//   - The first request to the new address appears in the cycle after redirect.
//  Address arithmetic: 32-bit wrap-around. 32'hFFFFFFFC+4 -> 0, with no error.
//  rst_n low mid-word abandons the word. mem_rd drops after that edge.
//  ir_data/ir_pc hold their value while ir_valid=1 and ir_ready=0.
// TESTING
//  1. Memory preloaded {00,00,00,08, 08,10,00,01}, ack=1, ir_ready=1.
//     Expect ir_valid in cycle 5 with ir_data=32'h00000008, ir_pc=0.
//     Expect cycle 9 with ir_data=32'h08100001, ir_pc=4.
//  2. ir_ready=0 for 20 cycles. Expect exactly FIFO_DEPTH words buffered and mem_rd=0 in FULL_WAIT.
//     Then ir_ready=1: words pop in order and fetch resumes in the same cycle as the first pop.
//  3. Redirect to 32'h40 while byte_cnt=2 and one word is buffered.
//     Expect the next ir_valid word to have ir_pc=32'h40, the stale word never presented,
//     and the first mem_addr=32'h40 one cycle after redirect.
//  4. mem_ack randomly 0 (~50%). Expect the word stream to match the memory image exactly,
//     with mem_addr/mem_rd stable while ack=0.
//  5. halt=1 at byte_cnt=1. Expect the word to complete and be pushed, then idle=1 and mem_rd=0.
//     halt=0 resumes at the next PC.
//  6. redirect_pc=32'hFFFFFFFE. Expect fetch from FFFFFFFC, then wrap to ir_pc=0.
//     Assert rst_n=0 mid-word: all outputs return to their reset values.

Source files
------------

// File: rtl/cpu0_ifetch_if.sv
// Bundle of the memory read port, the instruction handshake and the control
// inputs between the CPU0 fetch unit (master) and its environment (slave).
interface cpu0_ifetch_if;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_data;
  logic [31:0] ir_pc;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        idle;

  modport master (
    output mem_rd, mem_addr, ir_valid, ir_data, ir_pc, idle,
    input  mem_ack, mem_rdata, ir_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  mem_rd, mem_addr, ir_valid, ir_data, ir_pc, idle,
    output mem_ack, mem_rdata, ir_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/cpu0_ifetch.sv
// CPU0 instruction fetch: assembles big-endian words from a byte-wide memory
// port into a small FIFO and hands them to execute via valid/ready.
module cpu0_ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clock,
  input  logic            rst_n,
  cpu0_ifetch_if.master   bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_FETCH     = 2'd0;
  localparam logic [1:0] ST_FULL_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   asm_q, asm_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          mem_rd_q, mem_rd_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [31:0]   data_d [FIFO_DEPTH];
  logic [31:0]   pc_q   [FIFO_DEPTH];
  logic [31:0]   pc_d   [FIFO_DEPTH];

  logic ir_valid;
  logic xfer;
  logic push;
  logic pop;
  logic word_open;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ir_valid = (count_q != '0);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    fetch_pc_d = fetch_pc_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_d     = data_q;
    pc_d       = pc_q;
    word_open  = 1'b0;

    xfer = mem_rd_q & bus.mem_ack;
    push = xfer && (byte_cnt_q == 2'd3);
    pop  = ir_valid & bus.ir_ready;

    if (bus.redirect) begin
      // Flush wins over any same-cycle transfer, push or pop.
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      byte_cnt_d = 2'd0;
      fetch_pc_d = bus.redirect_pc & ~32'h3;
    end else begin
      if (xfer) begin
        asm_d      = {asm_q[15:0], bus.mem_rdata};
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
      if (push) begin
        data_d[wr_ptr_q] = {asm_q, bus.mem_rdata};
        pc_d[wr_ptr_q]   = fetch_pc_q;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
        fetch_pc_d       = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      word_open = mem_rd_q && !push;
    end

    // A started word always finishes; a new one needs reserved space and no halt.
    if (word_open) begin
      state_d  = ST_FETCH;
      mem_rd_d = 1'b1;
    end else if (bus.halt) begin
      state_d  = ST_HALTED;
      mem_rd_d = 1'b0;
    end else if (count_d < DEPTH_C) begin
      state_d  = ST_FETCH;
      mem_rd_d = 1'b1;
    end else begin
      state_d  = ST_FULL_WAIT;
      mem_rd_d = 1'b0;
    end

    if (mem_rd_d) begin
      mem_addr_d = fetch_pc_d + {30'd0, byte_cnt_d};
    end
  end

  // NOTE: sequential state uses <= only, so each flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      byte_cnt_q <= 2'd0;
      asm_q      <= '0;
      fetch_pc_q <= RESET_PC;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      // NOTE: the buffer is reset because its head drives ir_data/ir_pc directly.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      fetch_pc_q <= fetch_pc_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.ir_valid = ir_valid;
  assign bus.ir_data  = data_q[rd_ptr_q];
  assign bus.ir_pc    = pc_q[rd_ptr_q];
  assign bus.idle     = (state_q == ST_HALTED) && !mem_rd_q;

endmodule

// File: tb/tb_cpu0_ifetch.sv
// Directed bench for cpu0_ifetch: byte memory model, cycle-exact checks of
// fetch timing, back-pressure, redirect, random ack, halt, wrap and reset.
module tb_cpu0_ifetch;

  logic clock;
  logic rst_n;
  int   checks;
  int   errors;
  bit   rand_ack;
  logic rnd_bit;
  bit   mon_en;
  int   viol;
  logic        prev_rd;
  logic        prev_ack;
  logic [31:0] prev_addr;
  logic [31:0] exp_pc;

  cpu0_ifetch_if bus ();

  cpu0_ifetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h00;
      32'd1:   return 8'h00;
      32'd2:   return 8'h00;
      32'd3:   return 8'h08;
      32'd4:   return 8'h08;
      32'd5:   return 8'h10;
      32'd6:   return 8'h00;
      32'd7:   return 8'h01;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    return {mem_byte(pc), mem_byte(pc + 32'd1), mem_byte(pc + 32'd2), mem_byte(pc + 32'd3)};
  endfunction

  assign bus.mem_rdata = mem_byte(bus.mem_addr);
  assign bus.mem_ack   = rand_ack ? rnd_bit : 1'b1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // While a request is stalled, address and request must not move.
  always @(negedge clock) begin
    if (mon_en && prev_rd && !prev_ack &&
        (bus.mem_rd !== 1'b1 || bus.mem_addr !== prev_addr)) begin
      viol++;
    end
    prev_rd   = mon_en & bus.mem_rd;
    prev_ack  = bus.mem_ack;
    prev_addr = bus.mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc, input string tag);
    int n = 0;
    while (bus.ir_valid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.ir_valid), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    viol            = 0;
    rand_ack        = 1'b0;
    mon_en          = 1'b0;
    rst_n           = 1'b0;
    bus.ir_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt        = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_mem_rd",   32'(bus.mem_rd),   32'd0);
    check("rst_mem_addr", bus.mem_addr,      32'h0);
    check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
    check("rst_ir_data",  bus.ir_data,       32'h0);
    check("rst_ir_pc",    bus.ir_pc,         32'h0);
    check("rst_idle",     32'(bus.idle),     32'd0);

    // 1: first words, cycle-exact
    rst_n = 1'b1;               // cycle 0
    tick();                     // cycle 1
    check("t1_rd_c1",   32'(bus.mem_rd), 32'd1);
    check("t1_addr_c1", bus.mem_addr,    32'h0);
    tick(); tick(); tick();     // cycle 4
    check("t1_addr_c4",  bus.mem_addr,      32'h3);
    check("t1_nvld_c4",  32'(bus.ir_valid), 32'd0);
    tick();                     // cycle 5
    check("t1_vld_c5",  32'(bus.ir_valid), 32'd1);
    check("t1_data_c5", bus.ir_data,       32'h00000008);
    check("t1_pc_c5",   bus.ir_pc,         32'h0);
    tick(); tick(); tick();     // cycle 8
    check("t1_nvld_c8", 32'(bus.ir_valid), 32'd0);
    tick();                     // cycle 9
    check("t1_vld_c9",  32'(bus.ir_valid), 32'd1);
    check("t1_data_c9", bus.ir_data,       32'h08100001);
    check("t1_pc_c9",   bus.ir_pc,         32'h4);

    // 2: back-pressure fills the buffer, then drains in order
    bus.ir_ready = 1'b0;
    repeat (20) tick();
    check("t2_vld_full",  32'(bus.ir_valid), 32'd1);
    check("t2_pc_hold",   bus.ir_pc,         32'h4);
    check("t2_data_hold", bus.ir_data,       32'h08100001);
    check("t2_rd_full",   32'(bus.mem_rd),   32'd0);
    check("t2_idle_full", 32'(bus.idle),     32'd0);
    bus.ir_ready = 1'b1;
    tick();
    check("t2_pc_2nd",    bus.ir_pc,       32'h8);
    check("t2_data_2nd",  bus.ir_data,     exp_word(32'h8));
    check("t2_rd_resume", 32'(bus.mem_rd), 32'd1);
    check("t2_addr_res",  bus.mem_addr,    32'hC);
    tick();
    check("t2_empty", 32'(bus.ir_valid), 32'd0);

    // 3: redirect with one word buffered and byte_cnt=2
    bus.ir_ready = 1'b0;
    repeat (5) tick();
    check("t3_stale_vld", 32'(bus.ir_valid), 32'd1);
    check("t3_stale_pc",  bus.ir_pc,         32'hC);
    check("t3_addr_bc2",  bus.mem_addr,      32'h12);
    bus.redirect     = 1'b1;
    bus.redirect_pc  = 32'h40;
    bus.ir_ready     = 1'b1;
    tick();
    bus.redirect     = 1'b0;
    check("t3_rd_new",   32'(bus.mem_rd), 32'd1);
    check("t3_addr_new", bus.mem_addr,    32'h40);
    for (int i = 0; i < 4; i++) begin
      check("t3_no_stale", 32'(bus.ir_valid), 32'd0);
      tick();
    end
    check("t3_vld_40",  32'(bus.ir_valid), 32'd1);
    check("t3_pc_40",   bus.ir_pc,         32'h40);
    check("t3_data_40", bus.ir_data,       exp_word(32'h40));
    tick();

    // 4: random ack, stream must match memory image
    rand_ack = 1'b1;
    mon_en   = 1'b1;
    exp_pc   = 32'h44;
    for (int k = 0; k < 6; k++) begin
      wait_valid(200, "t4");
      check("t4_pc",   bus.ir_pc,   exp_pc);
      check("t4_data", bus.ir_data, exp_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      tick();
    end
    rand_ack = 1'b0;
    mon_en   = 1'b0;
    check("t4_stable", 32'(viol), 32'd0);

    // 5: halt in the middle of a word
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    check("t5_addr_b0", bus.mem_addr, 32'h100);
    tick();
    check("t5_addr_b1", bus.mem_addr, 32'h101);
    bus.halt = 1'b1;
    tick();
    check("t5_rd_cont",   32'(bus.mem_rd), 32'd1);
    check("t5_addr_b2",   bus.mem_addr,    32'h102);
    check("t5_idle_busy", 32'(bus.idle),   32'd0);
    tick(); tick();
    check("t5_vld",     32'(bus.ir_valid), 32'd1);
    check("t5_pc",      bus.ir_pc,         32'h100);
    check("t5_data",    bus.ir_data,       exp_word(32'h100));
    check("t5_idle",    32'(bus.idle),     32'd1);
    check("t5_rd_halt", 32'(bus.mem_rd),   32'd0);
    repeat (3) tick();
    check("t5_idle_hold", 32'(bus.idle),     32'd1);
    check("t5_rd_hold",   32'(bus.mem_rd),   32'd0);
    check("t5_vld_drain", 32'(bus.ir_valid), 32'd0);
    bus.halt = 1'b0;
    tick();
    check("t5_rd_res",   32'(bus.mem_rd), 32'd1);
    check("t5_addr_res", bus.mem_addr,    32'h104);
    check("t5_idle_res", 32'(bus.idle),   32'd0);
    wait_valid(20, "t5_res");
    check("t5_pc_res", bus.ir_pc, 32'h104);
    tick();

    // 6: wrap-around from the top of memory, then reset mid-word
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFFFFFE;
    tick();
    bus.redirect = 1'b0;
    check("t6_addr_top", bus.mem_addr, 32'hFFFFFFFC);
    wait_valid(20, "t6_top");
    check("t6_pc_top",   bus.ir_pc,   32'hFFFFFFFC);
    check("t6_data_top", bus.ir_data, exp_word(32'hFFFFFFFC));
    tick();
    wait_valid(20, "t6_wrap");
    check("t6_pc_wrap",   bus.ir_pc,   32'h0);
    check("t6_data_wrap", bus.ir_data, 32'h00000008);
    tick();
    check("t6_addr_mid", bus.mem_addr, 32'h5);
    rst_n = 1'b0;
    tick();
    check("t6_rst_rd",   32'(bus.mem_rd),   32'd0);
    check("t6_rst_addr", bus.mem_addr,      32'h0);
    check("t6_rst_vld",  32'(bus.ir_valid), 32'd0);
    check("t6_rst_data", bus.ir_data,       32'h0);
    check("t6_rst_pc",   bus.ir_pc,         32'h0);
    check("t6_rst_idle", 32'(bus.idle),     32'd0);
    rst_n = 1'b1;
    tick();
    check("t6_restart_rd",   32'(bus.mem_rd), 32'd1);
    check("t6_restart_addr", bus.mem_addr,    32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
